// File: rtl/exec_pkg.sv
// Shared types and field layout for the function executor stage.
package exec_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, DENY} estado_t;

  localparam int unsigned PERF_LSB = 0;
  localparam int unsigned PERF_W   = 3;
  localparam int unsigned FUNC_LSB = 3;
  localparam int unsigned FUNC_W   = 3;

  localparam logic [FUNC_W-1:0] FUNC_NONE = 3'd0;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for a synchronised level input; the register reset
// value is configurable so a level held through reset need not fire.
module detector_borda #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal,
  output logic borda_c
);

  logic sinal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sinal_q <= RST_VAL;
    else        sinal_q <= sinal;
  end

  assign borda_c = sinal & ~sinal_q;

endmodule

// File: rtl/executor_funcao.sv
// Captures the selector result on a confirm edge and runs a timed execution
// window or reports a denial. Optional completion counter: EXEC_COUNT_EN.
module executor_funcao
  import exec_pkg::*;
#(
  parameter int unsigned DUR_CYCLES = 100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       sel_in,
  input  logic             confirma,
  input  logic             cancela,
  output logic             ocupado,
  output logic [2:0]       func_ativa,
  output logic [2:0]       perfil_ativo,
  output logic [CNT_W-1:0] restante,
  output logic             concluido,
  output logic             negado,
  output logic             cancelado,
  output logic [7:0]       n_exec
);

  localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(DUR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DUR   = CNT_W'(DUR_CYCLES);

  logic              borda_c;
  logic [FUNC_W-1:0] func_sel;
  logic [PERF_W-1:0] perf_sel;

  estado_t           estado_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  restante_q;
  logic [FUNC_W-1:0] func_q;
  logic [PERF_W-1:0] perf_q;
  logic              ocupado_q;
  logic              concluido_q;
  logic              negado_q;
  logic              cancelado_q;

  // Register resets to 1 so a button held through reset is not an edge.
  detector_borda #(.RST_VAL(1'b1)) u_borda (
    .clk     (clk),
    .rst_n   (rst_n),
    .sinal   (confirma),
    .borda_c (borda_c)
  );

  assign func_sel = sel_in[FUNC_LSB +: FUNC_W];
  assign perf_sel = sel_in[PERF_LSB +: PERF_W];

  // Control FSM; restante tracks counter+1 so it is a plain register copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= IDLE;
      cnt_q       <= '0;
      restante_q  <= '0;
      func_q      <= '0;
      perf_q      <= '0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      negado_q    <= 1'b0;
      cancelado_q <= 1'b0;
    end else begin
      concluido_q <= 1'b0;
      negado_q    <= 1'b0;
      cancelado_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (borda_c) begin
            if (func_sel != FUNC_NONE) begin
              estado_q   <= RUN;
              func_q     <= func_sel;
              perf_q     <= perf_sel;
              cnt_q      <= CNT_CARGA;
              restante_q <= CNT_DUR;
              ocupado_q  <= 1'b1;
            end else begin
              estado_q <= DENY;
              negado_q <= 1'b1;
              func_q   <= '0;
              perf_q   <= '0;
            end
          end
        end
        RUN: begin
          if (cancela) begin
            estado_q    <= IDLE;
            cancelado_q <= 1'b1;
            ocupado_q   <= 1'b0;
            func_q      <= '0;
            perf_q      <= '0;
            cnt_q       <= '0;
            restante_q  <= '0;
          end else if (cnt_q == '0) begin
            estado_q    <= DONE;
            concluido_q <= 1'b1;
            ocupado_q   <= 1'b0;
            restante_q  <= '0;
          end else begin
            cnt_q      <= cnt_q - CNT_W'(1);
            restante_q <= cnt_q;
          end
        end
        DONE: begin
          estado_q <= IDLE;
          func_q   <= '0;
          perf_q   <= '0;
        end
        DENY: begin
          estado_q <= IDLE;
        end
        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

  assign ocupado      = ocupado_q;
  assign func_ativa   = func_q;
  assign perfil_ativo = perf_q;
  assign restante     = restante_q;
  assign concluido    = concluido_q;
  assign negado       = negado_q;
  assign cancelado    = cancelado_q;

`ifdef EXEC_COUNT_EN
  logic [7:0] n_exec_q;

  // Counts on the same edge that raises concluido; saturates at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_exec_q <= 8'd0;
    end else if (estado_q == RUN && !cancela && cnt_q == '0 && n_exec_q != 8'hFF) begin
      n_exec_q <= n_exec_q + 8'd1;
    end
  end

  assign n_exec = n_exec_q;
`else
  assign n_exec = 8'd0;
`endif

endmodule

// File: tb/tb_executor_funcao.sv
// Self-checking bench for executor_funcao: directed scenarios plus randomized
// runs against a window-level reference model.
module tb_executor_funcao;

  localparam int unsigned DUR = 4;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    sel_in;
  logic          confirma;
  logic          cancela;

  logic          ocupado, concluido, negado, cancelado;
  logic [2:0]    func_ativa, perfil_ativo;
  logic [CW-1:0] restante;
  logic [7:0]    n_exec;

  logic          ocupado1, concluido1, negado1, cancelado1;
  logic [2:0]    func_ativa1, perfil_ativo1;
  logic [CW-1:0] restante1;
  logic [7:0]    n_exec1;

  int checks = 0;
  int errors = 0;
  int exp_nexec = 0;

  typedef logic [25:0] vec_t;
  typedef logic [19:0] dvec_t;

  executor_funcao #(.DUR_CYCLES(DUR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .confirma(confirma), .cancela(cancela),
    .ocupado(ocupado), .func_ativa(func_ativa), .perfil_ativo(perfil_ativo),
    .restante(restante), .concluido(concluido), .negado(negado),
    .cancelado(cancelado), .n_exec(n_exec)
  );

  executor_funcao #(.DUR_CYCLES(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .confirma(confirma), .cancela(cancela),
    .ocupado(ocupado1), .func_ativa(func_ativa1), .perfil_ativo(perfil_ativo1),
    .restante(restante1), .concluido(concluido1), .negado(negado1),
    .cancelado(cancelado1), .n_exec(n_exec1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic vec_t mk(logic oc, logic [2:0] f, logic [2:0] p, logic [CW-1:0] r,
                              logic c, logic n, logic k);
    return {oc, f, p, r, c, n, k};
  endfunction

  function automatic vec_t obs();
    return {ocupado, func_ativa, perfil_ativo, restante, concluido, negado, cancelado};
  endfunction

  function automatic vec_t obs1();
    return {ocupado1, func_ativa1, perfil_ativo1, restante1, concluido1, negado1, cancelado1};
  endfunction

  // Completion cycle: latched fields are not compared there.
  function automatic dvec_t obs_done();
    return {ocupado, restante, concluido, negado, cancelado};
  endfunction

  localparam dvec_t DONE_V = {1'b0, 16'd0, 1'b1, 1'b0, 1'b0};

  function automatic logic [7:0] exp_n();
`ifdef EXEC_COUNT_EN
    return (exp_nexec > 255) ? 8'd255 : 8'(exp_nexec);
`else
    return 8'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; confirma = 1'b1; cancela = 1'b0; sel_in = 6'b101_001;
    repeat (3) step();
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    checks++;
    if (n_exec !== 8'd0) begin
      errors++; $display("FAIL reset_nexec: got %0d expected 0", n_exec);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL held_confirm_no_run: cycle %0d got %h expected 0", i, obs());
      end
    end
    confirma = 1'b0;
    step();
  endtask

  task automatic test_basic();
    sel_in = 6'b101_001; confirma = 1'b1;
    step();
    confirma = 1'b0;
    for (int i = 0; i < DUR; i++) begin
      checks++;
      if (obs() !== mk(1'b1, 3'd5, 3'd1, 16'(DUR - i), 1'b0, 1'b0, 1'b0)) begin
        errors++; $display("FAIL basic_run: cycle %0d got %h expected %h", i, obs(),
                           mk(1'b1, 3'd5, 3'd1, 16'(DUR - i), 1'b0, 1'b0, 1'b0));
      end
      step();
    end
    exp_nexec++;
    checks++;
    if (obs_done() !== DONE_V) begin
      errors++; $display("FAIL basic_done: got %h expected %h", obs_done(), DONE_V);
    end
    step();
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL basic_idle: got %h expected 0", obs());
    end
    checks++;
    if (n_exec !== exp_n()) begin
      errors++; $display("FAIL basic_nexec: got %0d expected %0d", n_exec, exp_n());
    end
  endtask

  task automatic test_deny();
    sel_in = 6'b000_011; confirma = 1'b1;
    step();
    confirma = 1'b0;
    checks++;
    if (obs() !== mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL deny_pulse: got %h expected %h", obs(),
                         mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL deny_after: cycle %0d got %h expected 0", i, obs());
      end
    end
  endtask

  task automatic test_cancel();
    sel_in = 6'b011_010; confirma = 1'b1;
    step();
    confirma = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs() !== mk(1'b1, 3'd3, 3'd2, 16'(DUR - i), 1'b0, 1'b0, 1'b0)) begin
        errors++; $display("FAIL cancel_run: cycle %0d got %h", i, obs());
      end
      if (i == 1) cancela = 1'b1;
      step();
    end
    cancela = 1'b0;
    checks++;
    if (obs() !== mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL cancel_pulse: got %h expected %h", obs(),
                         mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1));
    end
    for (int i = 0; i < DUR + 1; i++) begin
      step();
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL cancel_after: cycle %0d got %h expected 0", i, obs());
      end
    end
    checks++;
    if (n_exec !== exp_n()) begin
      errors++; $display("FAIL cancel_nexec: got %0d expected %0d", n_exec, exp_n());
    end
  endtask

  // Confirm/selector noise during a run, then cancel held in the final cycle.
  task automatic test_final_cancel();
    sel_in = 6'b110_100; confirma = 1'b1;
    step();
    for (int i = 0; i < DUR; i++) begin
      checks++;
      if (obs() !== mk(1'b1, 3'd6, 3'd4, 16'(DUR - i), 1'b0, 1'b0, 1'b0)) begin
        errors++; $display("FAIL noise_run: cycle %0d got %h", i, obs());
      end
      confirma = ~confirma;
      sel_in = 6'($urandom);
      cancela = (i == DUR - 1);
      step();
    end
    cancela = 1'b0; confirma = 1'b0;
    checks++;
    if (obs() !== mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL final_cancel_pulse: got %h", obs());
    end
    step();
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL final_cancel_no_done: got %h expected 0", obs());
    end
  endtask

  task automatic test_back_to_back();
    sel_in = 6'b001_111; confirma = 1'b1;
    step();
    confirma = 1'b0;
    repeat (DUR) step();
    exp_nexec++;
    checks++;
    if (obs_done() !== DONE_V) begin
      errors++; $display("FAIL b2b_done: got %h expected %h", obs_done(), DONE_V);
    end
    confirma = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL b2b_ignored_edge: cycle %0d got %h expected 0", i, obs());
      end
    end
    confirma = 1'b0;
    step();
    sel_in = 6'b111_101; confirma = 1'b1;
    step();
    confirma = 1'b0;
    checks++;
    if (obs() !== mk(1'b1, 3'd7, 3'd5, 16'(DUR), 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL b2b_restart: got %h", obs());
    end
    repeat (DUR + 1) step();
    exp_nexec++;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL b2b_final_idle: got %h expected 0", obs());
    end
  endtask

  task automatic test_dur1();
    sel_in = 6'b010_110; confirma = 1'b1;
    step();
    confirma = 1'b0;
    checks++;
    if (obs1() !== mk(1'b1, 3'd2, 3'd6, 16'd1, 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL dur1_run: got %h", obs1());
    end
    step();
    checks++;
    if ({ocupado1, restante1, concluido1, negado1, cancelado1} !== DONE_V) begin
      errors++; $display("FAIL dur1_done: got %h expected %h",
                         {ocupado1, restante1, concluido1, negado1, cancelado1}, DONE_V);
    end
    step();
    checks++;
    if (obs1() !== '0) begin
      errors++; $display("FAIL dur1_idle: got %h expected 0", obs1());
    end
    repeat (DUR - 1) step();
    exp_nexec++;
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL dur1_main_idle: got %h expected 0", obs());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [2:0] f, p;
      int cidx;
      f = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      p = 3'($urandom);
      cidx = $urandom_range(0, DUR + 1);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        cancela = 1'($urandom);
        sel_in = 6'($urandom);
        step();
        checks++;
        if (obs() !== '0) begin
          errors++; $display("FAIL rnd_idle: iter %0d got %h expected 0", it, obs());
        end
      end
      cancela = 1'b0;
      sel_in = {f, p}; confirma = 1'b1;
      step();
      confirma = 1'b0;
      if (f == 3'd0) begin
        checks++;
        if (obs() !== mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0)) begin
          errors++; $display("FAIL rnd_deny: iter %0d got %h", it, obs());
        end
      end else begin
        for (int i = 0; i < DUR; i++) begin
          checks++;
          if (obs() !== mk(1'b1, f, p, 16'(DUR - i), 1'b0, 1'b0, 1'b0)) begin
            errors++; $display("FAIL rnd_run: iter %0d cycle %0d got %h expected %h", it, i,
                               obs(), mk(1'b1, f, p, 16'(DUR - i), 1'b0, 1'b0, 1'b0));
          end
          confirma = 1'($urandom);
          sel_in = 6'($urandom);
          cancela = (i == cidx);
          step();
          if (i == cidx) break;
        end
        cancela = 1'b0; confirma = 1'b0;
        if (cidx < DUR) begin
          checks++;
          if (obs() !== mk(1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b1)) begin
            errors++; $display("FAIL rnd_cancel: iter %0d got %h", it, obs());
          end
        end else begin
          exp_nexec++;
          checks++;
          if (obs_done() !== DONE_V) begin
            errors++; $display("FAIL rnd_done: iter %0d got %h expected %h", it, obs_done(), DONE_V);
          end
        end
      end
      step();
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL rnd_end_idle: iter %0d got %h expected 0", it, obs());
      end
    end
    checks++;
    if (n_exec !== exp_n()) begin
      errors++; $display("FAIL rnd_nexec: got %0d expected %0d", n_exec, exp_n());
    end
  endtask

`ifdef EXEC_COUNT_EN
  task automatic test_saturation();
    for (int r = 0; r < 257; r++) begin
      sel_in = 6'b001_000; confirma = 1'b1;
      step();
      confirma = 1'b0;
      repeat (DUR + 1) step();
      exp_nexec++;
    end
    checks++;
    if (n_exec !== 8'd255 || n_exec !== exp_n()) begin
      errors++; $display("FAIL nexec_saturate: got %0d expected 255", n_exec);
    end
  endtask
`endif

  task automatic test_reset_midrun();
    sel_in = 6'b100_010; confirma = 1'b1;
    step();
    confirma = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    exp_nexec = 0;
    checks++;
    if (obs() !== '0 || obs1() !== '0) begin
      errors++; $display("FAIL midrun_reset: got %h / %h expected 0", obs(), obs1());
    end
    checks++;
    if (n_exec !== exp_n()) begin
      errors++; $display("FAIL midrun_reset_nexec: got %0d expected 0", n_exec);
    end
    rst_n = 1'b1;
    repeat (DUR + 1) step();
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL midrun_no_pulse: got %h expected 0", obs());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deny();
    test_cancel();
    test_final_cancel();
    test_back_to_back();
    test_dur1();
    test_random();
`ifdef EXEC_COUNT_EN
    test_saturation();
`endif
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
